// File: rtl/seq_compare.sv
// Multi-cycle magnitude comparator that walks the operands MSB slice first, DIGIT bits per cycle.
// It stops at the first differing slice. Unsigned and two's-complement modes are supported.
module seq_compare #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             state_dbg
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    // Handshake: start is sampled only in IDLE. The done pulse lands in IDLE, so a start
    // asserted during the done cycle is accepted and runs back-to-back. Start in RUN is ignored.
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               mode_q;
    logic [IW-1:0]      idx, idx_nxt;
    logic [DIGIT-1:0]   slice_a, slice_b;
    logic               finish;
    logic               res_x, res_y, res_z;

    // Offset-binary trick: flipping the sign bit of slice 0 lets every slice compare unsigned.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                slice_a = a_q[WIDTH-1-i*DIGIT -: DIGIT];
                slice_b = b_q[WIDTH-1-i*DIGIT -: DIGIT];
            end
        end
        if (mode_q && idx == '0) begin
            slice_a[DIGIT-1] = ~slice_a[DIGIT-1];
            slice_b[DIGIT-1] = ~slice_b[DIGIT-1];
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        finish    = 1'b0;
        res_x     = 1'b0;
        res_y     = 1'b0;
        res_z     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                end
            end
            RUN: begin
                if (slice_a != slice_b) begin
                    finish    = 1'b1;
                    res_x     = (slice_a > slice_b);
                    res_y     = !(slice_a > slice_b);
                    state_nxt = IDLE;
                end else if (idx == LAST) begin
                    finish    = 1'b1;
                    res_z     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            done   <= 1'b0;
            x      <= 1'b0;
            y      <= 1'b0;
            z      <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            done  <= finish;
            if (state == IDLE && start) begin
                a_q    <= a;
                b_q    <= b;
                mode_q <= signed_mode;
            end
            if (finish) begin
                x <= res_x;
                y <= res_y;
                z <= res_z;
            end
        end
    end

    assign busy      = (state == RUN);
    assign state_dbg = (state == RUN);

endmodule

// File: tb/tb_seq_compare.sv
// Scoreboard bench for seq_compare with three configurations: 16/4, 8/1 and 8/8.
// Expected result and latency are pushed on start and popped when done pulses.
module tb_seq_compare;

    localparam int EW = 11;  // {latency[7:0], x, y, z}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start = '0;
    logic [2:0]  mode = '0;
    logic [15:0] a0 = '0, b0 = '0;
    logic [7:0]  a1 = '0, b1 = '0, a2 = '0, b2 = '0;
    logic [2:0]  busy, done, x, y, z, st;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc [3];
    logic [2:0] last_xyz [3];
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];

    seq_compare #(.WIDTH(16), .DIGIT(4)) u_c16 (
        .clk(clk), .rst(rst), .start(start[0]), .signed_mode(mode[0]), .a(a0), .b(b0),
        .busy(busy[0]), .done(done[0]), .x(x[0]), .y(y[0]), .z(z[0]), .state_dbg(st[0]));
    seq_compare #(.WIDTH(8), .DIGIT(1)) u_c8d1 (
        .clk(clk), .rst(rst), .start(start[1]), .signed_mode(mode[1]), .a(a1), .b(b1),
        .busy(busy[1]), .done(done[1]), .x(x[1]), .y(y[1]), .z(z[1]), .state_dbg(st[1]));
    seq_compare #(.WIDTH(8), .DIGIT(8)) u_c8d8 (
        .clk(clk), .rst(rst), .start(start[2]), .signed_mode(mode[2]), .a(a2), .b(b2),
        .busy(busy[2]), .done(done[2]), .x(x[2]), .y(y[2]), .z(z[2]), .state_dbg(st[2]));

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int wd(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic int dg(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    // reference model: true magnitude compare plus first-differing-slice latency
    function automatic logic [EW-1:0] model(input int d, input logic [15:0] av,
                                            input logic [15:0] bv, input logic m);
        int w, dgt, n, mask, smask, ua, ub, ia, ib, lat;
        logic [7:0] lat8;
        logic [2:0] xyz;
        bit found;
        w = wd(d); dgt = dg(d); n = w / dgt;
        mask = (1 << w) - 1; smask = (1 << dgt) - 1;
        ua = int'(av) & mask; ub = int'(bv) & mask;
        ia = ua; ib = ub;
        if (m && av[w-1]) ia = ia - (1 << w);
        if (m && bv[w-1]) ib = ib - (1 << w);
        xyz = (ia > ib) ? 3'b100 : ((ia < ib) ? 3'b010 : 3'b001);
        lat = n; found = 0;
        for (int k = 0; k < n; k++) begin
            if (!found && (((ua >> (w - (k + 1) * dgt)) & smask) != ((ub >> (w - (k + 1) * dgt)) & smask))) begin
                lat = k + 1;
                found = 1;
            end
        end
        lat8 = lat[7:0];
        return {lat8, xyz};
    endfunction

    // driver: call just after a negedge; returns #1 after the sampling edge
    task automatic do_start(input int d, input logic [15:0] av, input logic [15:0] bv,
                            input logic m, input bit push);
        logic [EW-1:0] e;
        e = model(d, av, bv, m);
        if (push) begin
            case (d)
                0:       exp_q0.push_back(e);
                1:       exp_q1.push_back(e);
                default: exp_q2.push_back(e);
            endcase
        end
        case (d)
            0:       begin a0 = av;      b0 = bv;      end
            1:       begin a1 = av[7:0]; b1 = bv[7:0]; end
            default: begin a2 = av[7:0]; b2 = bv[7:0]; end
        endcase
        mode[d] = m;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start_cyc[d] = cyc;
        start[d] = 1'b0;
        check("busy_after_start", {31'd0, busy[d]}, 32'd1);
    endtask

    task automatic wait_all(input int d);
        for (int i = 0; i < 40 && qsize(d) != 0; i++) @(negedge clk);
        if (qsize(d) != 0) begin
            check("done_timeout", qsize(d), 0);
            case (d)
                0:       exp_q0.delete();
                1:       exp_q1.delete();
                default: exp_q2.delete();
            endcase
        end
        @(negedge clk);
        @(negedge clk);
        check("hold_xyz", {29'd0, x[d], y[d], z[d]}, {29'd0, last_xyz[d]});
    endtask

    task automatic run_cmp(input int d, input logic [15:0] av, input logic [15:0] bv, input logic m);
        @(negedge clk);
        do_start(d, av, bv, m, 1'b1);
        wait_all(d);
    endtask

    // scoreboard: pop and compare on every done pulse
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        bit got;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (done[d]) begin
                    got = 0;
                    e = '0;
                    case (d)
                        0:       if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); got = 1; end
                        1:       if (exp_q1.size() != 0) begin e = exp_q1.pop_front(); got = 1; end
                        default: if (exp_q2.size() != 0) begin e = exp_q2.pop_front(); got = 1; end
                    endcase
                    if (!got) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        check("latency", cyc - start_cyc[d], {24'd0, e[10:3]});
                        check("xyz", {29'd0, x[d], y[d], z[d]}, {29'd0, e[2:0]});
                        check("busy_in_done", {31'd0, busy[d]}, 32'd0);
                        last_xyz[d] = e[2:0];
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        for (int d = 0; d < 3; d++) begin
            start_cyc[d] = 0;
            last_xyz[d] = 3'b000;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            check("reset_outputs", {27'd0, busy[d], done[d], x[d], y[d], z[d]}, 32'd0);
        rst = 1'b0;

        // 16-bit, 4-bit slices
        run_cmp(0, 16'h7000, 16'h3000, 1'b0);
        run_cmp(0, 16'h1234, 16'h1235, 1'b0);
        run_cmp(0, 16'h12F0, 16'h1200, 1'b0);
        run_cmp(0, 16'hBEEF, 16'hBEEF, 1'b0);
        run_cmp(0, 16'hBEEF, 16'hBEEF, 1'b1);
        run_cmp(0, 16'h8000, 16'h0001, 1'b1);
        run_cmp(0, 16'h8000, 16'h0001, 1'b0);
        run_cmp(0, 16'hFFFF, 16'hFFFE, 1'b1);
        run_cmp(0, 16'h7FFF, 16'h8000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = (i % 2 == 0) ? {ra[15:4], 4'($urandom_range(0, 15))} : 16'($urandom_range(0, 65535));
            run_cmp(0, ra, rb, 1'($urandom_range(0, 1)));
        end

        // start and operand changes during RUN are ignored
        @(negedge clk);
        do_start(0, 16'h1234, 16'h1235, 1'b0, 1'b1);
        @(negedge clk);
        a0 = 16'hFFFF; b0 = 16'h0000; mode[0] = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; a0 = 16'h0000; b0 = 16'hFFFF;
        wait_all(0);

        // back-to-back: restart in the done cycle
        @(negedge clk);
        do_start(0, 16'h7000, 16'h3000, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !done[0]; i++) @(negedge clk);
        do_start(0, 16'h1234, 16'h1235, 1'b0, 1'b1);
        wait_all(0);

        // reset mid-RUN aborts without a done
        @(negedge clk);
        do_start(0, 16'h1234, 16'h1235, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", {27'd0, busy[0], done[0], x[0], y[0], z[0]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_abort_xyz", {29'd0, x[0], y[0], z[0]}, 32'd0);
        run_cmp(0, 16'd5, 16'd9, 1'b0);

        // 8-bit configurations
        for (int d = 1; d < 3; d++) begin
            run_cmp(d, 16'h0070, 16'h0030, 1'b0);
            run_cmp(d, 16'h0012, 16'h0013, 1'b0);
            run_cmp(d, 16'h00BE, 16'h00BE, 1'b0);
            run_cmp(d, 16'h00BE, 16'h00BE, 1'b1);
            run_cmp(d, 16'h0080, 16'h0001, 1'b1);
            run_cmp(d, 16'h0080, 16'h0001, 1'b0);
            run_cmp(d, 16'h00FF, 16'h00FE, 1'b1);
            for (int i = 0; i < 4; i++)
                run_cmp(d, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            do_start(d, 16'h0005, 16'h0009, 1'b0, 1'b1);
            for (int i = 0; i < 20 && !done[d]; i++) @(negedge clk);
            do_start(d, 16'h0081, 16'h0002, 1'b1, 1'b1);
            wait_all(d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_compare.md
# seq_compare

Parametrised, multi-cycle magnitude comparator, successor to the 4-bit combinational comparator. Compares two WIDTH-bit operands a slice of DIGIT bits per clock, MSB slice first, and terminates early on the first differing slice. Supports unsigned and two's-complement modes and uses a start/done handshake. Results are registered and held until the next completed compare. Sits wherever a narrow, low-area ordering decision is needed between registered datapath values.

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits examined per cycle; 1 ≤ DIGIT ≤ WIDTH.
- N (localparam), WIDTH/DIGIT, number of slices.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request compare; sampled only in IDLE.
- signed_mode  input  1  1 means two's-complement operands, 0 means unsigned; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while a compare is in progress (RUN).
- done  output  1  one-cycle pulse; x/y/z are valid and updated in the same cycle.
- x  output  1  a > b.
- y  output  1  a < b.
- z  output  1  a == b.

## Operation
- States: IDLE, RUN. Internal registers: a_q, b_q, mode_q, slice index idx (ceil(log2 N) bits, minimum 1).
- IDLE: if start=1 at a rising edge, latch a, b and signed_mode, set idx=0 and move to RUN. Otherwise hold.
- RUN: each edge evaluates slice idx, i.e. bits [WIDTH-1-idx*DIGIT -: DIGIT] of a_q and b_q.
- Signed mode: the operand MSB is inverted in slice 0 only (offset-binary mapping). All slices are then compared unsigned.
- If the slices differ: x = (slice_a > slice_b), y = !x, z = 0. Pulse done and return to IDLE.
- If the slices are equal and idx == N-1: x = 0, y = 0, z = 1. Pulse done and return to IDLE.
- If the slices are equal and idx < N-1: increment idx and stay in RUN.
- Exactly one of x/y/z is high after any completed compare.
- start in RUN is ignored: no queueing, and latched operands do not change.
- Changing a, b or signed_mode during RUN has no effect.
- N=1 (DIGIT=WIDTH) degenerates to a single-cycle registered compare.

## Timing
- Reset values: state=IDLE, busy=0, done=0, x=0, y=0, z=0, idx=0.
- Call the edge that samples start in IDLE edge S.
  - busy rises after edge S.
  - done and the new x/y/z appear after edge S+k, where k = (index of first differing slice)+1. If all slices are equal, k=N.
  - Latency range is 1..N cycles.
- busy falls in the same cycle done rises.
- done is high for exactly one cycle.
- x/y/z change only in done cycles or on reset.
- The done cycle is in IDLE, so a start sampled at the end of the done cycle is accepted: back-to-back operation, one idle-free restart.
- Reset mid-RUN: immediate return to IDLE with all outputs at their reset values. No done is issued for the aborted compare.
- rst takes priority over start at the same edge.

## Test plan
Default parameters for all scenarios: WIDTH=16, DIGIT=4, N=4.
- Early exit, greater: unsigned, a=0x7000, b=0x3000. Response: done 1 cycle after start; x=1, y=0, z=0; busy high for 1 cycle.
- Late exit, less: unsigned, a=0x1234, b=0x1235. Response: done 4 cycles after start; y=1. Also a=0x12F0, b=0x1200: done 3 cycles after start; x=1.
- Equality: a=b=0xBEEF, both modes. Response: done 4 cycles after start; z=1, x=0, y=0.
- Sign handling: a=0x8000, b=0x0001.
  - signed_mode=1: y=1 in 1 cycle (-32768 < 1).
  - signed_mode=0: x=1.
  - a=0xFFFF, b=0xFFFE, signed: x=1 after 4 cycles (-1 > -2).
- Handshake: pulse start again during RUN with different operands. Response: ignored; result matches the first operands.
  - Assert start in the done cycle. Response: second compare begins and its done is issued at the correct latency.
  - Change a/b during RUN. Response: no effect.
- Reset mid-operation: start with a=0x1234, b=0x1235, then assert rst after 2 cycles. Response: busy=0, done never pulses, x=y=z=0.
  - After releasing rst, a=5, b=9 unsigned. Response: y=1 after 4 cycles.
  - Repeat the key cases with WIDTH=8, DIGIT=1 and with WIDTH=8, DIGIT=8.
